// File: rtl/memory_write_split_pkg.sv
// Shared defines for the write splitter: FSM state encodings and boolean constants.
package memory_write_split_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_FIRST  = 2'd1,
        STATE_SECOND = 2'd2
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/memory_write_split_piece_calc.sv
// Combinational split arithmetic for a 1..4 byte access against a 2^LINE_LOG2 line.
module write_piece_calc #(
    parameter int LINE_LOG2 = 4,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic [31:0] address,
    input  logic [2:0]  length,
    input  logic [31:0] data,
    output logic [2:0]  len1,
    output logic [2:0]  len2,
    output logic [31:0] addr2,
    output logic [31:0] data2
);
    localparam int LW = LINE_LOG2 + 1;

    logic [LW-1:0] left;
    logic          split;

    assign left  = LW'(2 ** LINE_LOG2) - LW'(address[LINE_LOG2-1:0]);
    // left can only be below a 1..4 length when it is at most 3, so left[2:0] is exact
    assign split = SPLIT_EN && (left < LW'(length));
    assign len1  = split ? left[2:0] : length;
    assign len2  = length - len1;
    assign addr2 = {address[31:LINE_LOG2] + (32 - LINE_LOG2)'(1), {LINE_LOG2{1'b0}}};
    assign data2 = data >> {len1, 3'b000};

endmodule

// File: rtl/memory_write_split.sv
// Splits a 1..4 byte write into one or two TLB write pieces, with sticky faults and flush abort.
module memory_write_split
    import memory_write_split_pkg::*;
#(
    parameter int LINE_LOG2 = 4,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_reset,
    input  logic        write_do,
    output logic        write_done,
    output logic        write_page_fault,
    output logic        write_ac_fault,
    input  logic [1:0]  write_cpl,
    input  logic [31:0] write_address,
    input  logic [2:0]  write_length,
    input  logic        write_lock,
    input  logic        write_rmw,
    input  logic [31:0] write_data,
    output logic        tlbwrite_do,
    input  logic        tlbwrite_done,
    input  logic        tlbwrite_page_fault,
    input  logic        tlbwrite_ac_fault,
    output logic [1:0]  tlbwrite_cpl,
    output logic        tlbwrite_lock,
    output logic        tlbwrite_rmw,
    output logic [2:0]  tlbwrite_length_full,
    output logic [31:0] tlbwrite_address,
    output logic [2:0]  tlbwrite_length,
    output logic [31:0] tlbwrite_data,
    output logic        tlbwrite_second
);
    state_t      state, state_nxt;
    logic        reset_waiting;
    logic        sticky_pf, sticky_ac;
    logic [2:0]  len2_q;
    logic [31:0] addr2_q, data2_q;

    logic [2:0]  len1, len2;
    logic [31:0] addr2, data2;
    logic        accept, do_c, second_c, done_c, fault_in;

    write_piece_calc #(.LINE_LOG2(LINE_LOG2), .SPLIT_EN(SPLIT_EN)) u_calc (
        .address (write_address),
        .length  (write_length),
        .data    (write_data),
        .len1    (len1),
        .len2    (len2),
        .addr2   (addr2),
        .data2   (data2)
    );

    assign write_page_fault = tlbwrite_page_fault | sticky_pf;
    assign write_ac_fault   = tlbwrite_ac_fault | sticky_ac;
    assign fault_in         = tlbwrite_page_fault | tlbwrite_ac_fault;

    always_comb begin
        state_nxt = state;
        accept    = FALSE;
        do_c      = FALSE;
        second_c  = FALSE;
        done_c    = FALSE;
        case (state)
            STATE_IDLE: begin
                if (write_do && !wr_reset && !write_page_fault && !write_ac_fault) begin
                    accept    = TRUE;
                    do_c      = TRUE;
                    state_nxt = STATE_FIRST;
                end
            end
            STATE_FIRST: begin
                do_c = TRUE;
                if (fault_in) begin
                    state_nxt = STATE_IDLE;
                end else if (tlbwrite_done) begin
                    if (len2_q != 3'd0) begin
                        state_nxt = STATE_SECOND;
                    end else begin
                        done_c    = !reset_waiting;
                        state_nxt = STATE_IDLE;
                    end
                end
            end
            STATE_SECOND: begin
                do_c     = TRUE;
                second_c = TRUE;
                if (fault_in) begin
                    state_nxt = STATE_IDLE;
                end else if (tlbwrite_done) begin
                    done_c    = !reset_waiting;
                    state_nxt = STATE_IDLE;
                end
            end
            default: state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= STATE_IDLE;
            reset_waiting <= FALSE;
            sticky_pf     <= FALSE;
            sticky_ac     <= FALSE;
            len2_q        <= '0;
            addr2_q       <= '0;
            data2_q       <= '0;
        end else begin
            state         <= state_nxt;
            reset_waiting <= (state == STATE_IDLE) ? FALSE : (reset_waiting | wr_reset);
            // a flush drops faults of the aborted write, including one arriving this cycle
            sticky_pf     <= wr_reset ? FALSE : (sticky_pf | (tlbwrite_page_fault & ~reset_waiting));
            sticky_ac     <= wr_reset ? FALSE : (sticky_ac | (tlbwrite_ac_fault & ~reset_waiting));
            if (accept) begin
                len2_q  <= len2;
                addr2_q <= addr2;
                data2_q <= data2;
            end
        end
    end

    assign tlbwrite_do          = do_c & ~rst;
    assign tlbwrite_second      = second_c & ~rst;
    assign write_done           = done_c & ~rst;
    assign tlbwrite_cpl         = write_cpl;
    assign tlbwrite_lock        = write_lock;
    assign tlbwrite_rmw         = write_rmw;
    assign tlbwrite_length_full = write_length;
    assign tlbwrite_address     = second_c ? addr2_q : write_address;
    assign tlbwrite_length      = second_c ? len2_q  : len1;
    assign tlbwrite_data        = second_c ? data2_q : write_data;

endmodule

// File: tb/tb_memory_write_split.sv
// Directed bench: main instance at LINE_LOG2=4, plus LINE_LOG2=2 instances with and without splitting.
module tb_memory_write_split;
    logic        clk = 1'b0;
    logic        rst, wr_reset, tdone, tpf, tac, lock, rmw;
    logic        do_m, do_w, do_n;
    logic [1:0]  cpl;
    logic [31:0] addr, data;
    logic [2:0]  len;

    logic        done_m, pf_m, ac_m, tdo_m, lck_m, rmw_m, sec_m;
    logic [1:0]  cpl_m;
    logic [2:0]  lf_m, tl_m;
    logic [31:0] ta_m, td_m;
    logic        done_w, pf_w, ac_w, tdo_w, lck_w, rmw_w, sec_w;
    logic [1:0]  cpl_w;
    logic [2:0]  lf_w, tl_w;
    logic [31:0] ta_w, td_w;
    logic        done_n, pf_n, ac_n, tdo_n, lck_n, rmw_n, sec_n;
    logic [1:0]  cpl_n;
    logic [2:0]  lf_n, tl_n;
    logic [31:0] ta_n, td_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_write_split dut (
        .clk(clk), .rst(rst), .wr_reset(wr_reset), .write_do(do_m), .write_done(done_m),
        .write_page_fault(pf_m), .write_ac_fault(ac_m), .write_cpl(cpl), .write_address(addr),
        .write_length(len), .write_lock(lock), .write_rmw(rmw), .write_data(data),
        .tlbwrite_do(tdo_m), .tlbwrite_done(tdone), .tlbwrite_page_fault(tpf), .tlbwrite_ac_fault(tac),
        .tlbwrite_cpl(cpl_m), .tlbwrite_lock(lck_m), .tlbwrite_rmw(rmw_m), .tlbwrite_length_full(lf_m),
        .tlbwrite_address(ta_m), .tlbwrite_length(tl_m), .tlbwrite_data(td_m), .tlbwrite_second(sec_m));

    memory_write_split #(.LINE_LOG2(2), .SPLIT_EN(1'b1)) dut_w (
        .clk(clk), .rst(rst), .wr_reset(wr_reset), .write_do(do_w), .write_done(done_w),
        .write_page_fault(pf_w), .write_ac_fault(ac_w), .write_cpl(cpl), .write_address(addr),
        .write_length(len), .write_lock(lock), .write_rmw(rmw), .write_data(data),
        .tlbwrite_do(tdo_w), .tlbwrite_done(tdone), .tlbwrite_page_fault(tpf), .tlbwrite_ac_fault(tac),
        .tlbwrite_cpl(cpl_w), .tlbwrite_lock(lck_w), .tlbwrite_rmw(rmw_w), .tlbwrite_length_full(lf_w),
        .tlbwrite_address(ta_w), .tlbwrite_length(tl_w), .tlbwrite_data(td_w), .tlbwrite_second(sec_w));

    memory_write_split #(.LINE_LOG2(2), .SPLIT_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .wr_reset(wr_reset), .write_do(do_n), .write_done(done_n),
        .write_page_fault(pf_n), .write_ac_fault(ac_n), .write_cpl(cpl), .write_address(addr),
        .write_length(len), .write_lock(lock), .write_rmw(rmw), .write_data(data),
        .tlbwrite_do(tdo_n), .tlbwrite_done(tdone), .tlbwrite_page_fault(tpf), .tlbwrite_ac_fault(tac),
        .tlbwrite_cpl(cpl_n), .tlbwrite_lock(lck_n), .tlbwrite_rmw(rmw_n), .tlbwrite_length_full(lf_n),
        .tlbwrite_address(ta_n), .tlbwrite_length(tl_n), .tlbwrite_data(td_n), .tlbwrite_second(sec_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive just after the rising edge; checks follow after a short settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; wr_reset = 1'b0; tdone = 1'b0; tpf = 1'b1; tac = 1'b0;
        lock = 1'b0; rmw = 1'b0; cpl = 2'd3;
        do_m = 1'b1; do_w = 1'b0; do_n = 1'b0;
        addr = 32'h1000; len = 3'd4; data = 32'hAABBCCDD;
        tick(); tick(); settle();
        chk("rst_tdo", {31'b0, tdo_m}, 32'd0);
        chk("rst_done", {31'b0, done_m}, 32'd0);
        chk("rst_pf_mirror", {31'b0, pf_m}, 32'd1);
        chk("rst_cpl_pass", {30'b0, cpl_m}, 32'd3);

        // unsplit write
        tick(); rst = 1'b0; tpf = 1'b0; do_m = 1'b1; settle();
        chk("post_rst_pf", {31'b0, pf_m}, 32'd0);
        chk("u_tdo", {31'b0, tdo_m}, 32'd1);
        chk("u_len", {29'b0, tl_m}, 32'd4);
        chk("u_addr", ta_m, 32'h1000);
        chk("u_data", td_m, 32'hAABBCCDD);
        tick(); settle();
        chk("u_wait_tdo", {31'b0, tdo_m}, 32'd1);
        chk("u_wait_done", {31'b0, done_m}, 32'd0);
        tick(); tdone = 1'b1; settle();
        chk("u_done", {31'b0, done_m}, 32'd1);
        chk("u_second", {31'b0, sec_m}, 32'd0);
        tick(); tdone = 1'b0; do_m = 1'b0; settle();
        chk("u_idle_tdo", {31'b0, tdo_m}, 32'd0);
        chk("u_idle_done", {31'b0, done_m}, 32'd0);

        // split write across 0x1010
        addr = 32'h100E; data = 32'h44332211; lock = 1'b1; do_m = 1'b1; settle();
        chk("s1_len", {29'b0, tl_m}, 32'd2);
        chk("s1_addr", ta_m, 32'h100E);
        chk("s1_data", td_m, 32'h44332211);
        chk("s1_lenfull", {29'b0, lf_m}, 32'd4);
        tick(); tdone = 1'b1; settle();
        chk("s1_done_none", {31'b0, done_m}, 32'd0);
        tick(); tdone = 1'b0; settle();
        chk("s2_second", {31'b0, sec_m}, 32'd1);
        chk("s2_addr", ta_m, 32'h1010);
        chk("s2_len", {29'b0, tl_m}, 32'd2);
        chk("s2_data", td_m, 32'h00004433);
        chk("s2_lock", {31'b0, lck_m}, 32'd1);
        chk("s2_no_done", {31'b0, done_m}, 32'd0);
        tick(); tdone = 1'b1; settle();
        chk("s2_done", {31'b0, done_m}, 32'd1);
        tick(); tdone = 1'b0; do_m = 1'b0; lock = 1'b0; settle();
        chk("s_idle_sec", {31'b0, sec_m}, 32'd0);

        // address wrap on the small-line instances
        addr = 32'hFFFFFFFF; len = 3'd2; data = 32'h0000BBAA; do_w = 1'b1; do_n = 1'b1; settle();
        chk("w1_len", {29'b0, tl_w}, 32'd1);
        chk("n1_len", {29'b0, tl_n}, 32'd2);
        chk("w1_addr", ta_w, 32'hFFFFFFFF);
        tick(); tdone = 1'b1; settle();
        chk("n_done", {31'b0, done_n}, 32'd1);
        chk("w1_no_done", {31'b0, done_w}, 32'd0);
        tick(); do_n = 1'b0; settle();
        chk("w2_addr", ta_w, 32'h00000000);
        chk("w2_len", {29'b0, tl_w}, 32'd1);
        chk("w2_data", td_w, 32'h000000BB);
        chk("w2_done", {31'b0, done_w}, 32'd1);
        chk("n_idle", {31'b0, tdo_n}, 32'd0);
        tick(); tdone = 1'b0; do_w = 1'b0; settle();
        chk("w_idle", {31'b0, tdo_w}, 32'd0);

        // page fault on piece 1 of a split write
        addr = 32'h100E; len = 3'd4; data = 32'h44332211; do_m = 1'b1;
        tick(); tpf = 1'b1; settle();
        chk("f_pf_live", {31'b0, pf_m}, 32'd1);
        chk("f_no_done", {31'b0, done_m}, 32'd0);
        tick(); tpf = 1'b0; settle();
        chk("f_sticky", {31'b0, pf_m}, 32'd1);
        chk("f_refused", {31'b0, tdo_m}, 32'd0);
        tick(); settle();
        chk("f_no_piece2", {31'b0, sec_m}, 32'd0);
        chk("f_still_refused", {31'b0, tdo_m}, 32'd0);
        wr_reset = 1'b1; settle();
        chk("f_wrreset_blocks", {31'b0, tdo_m}, 32'd0);
        tick(); wr_reset = 1'b0; addr = 32'h1000; settle();
        chk("f_cleared", {31'b0, pf_m}, 32'd0);
        chk("f_accept", {31'b0, tdo_m}, 32'd1);
        tick(); tdone = 1'b1; settle();
        chk("f_after_done", {31'b0, done_m}, 32'd1);
        tick(); tdone = 1'b0; do_m = 1'b0;

        // abort mid-write
        do_m = 1'b1;
        tick(); wr_reset = 1'b1; settle();
        chk("a_tdo_held", {31'b0, tdo_m}, 32'd1);
        tick(); wr_reset = 1'b0; tdone = 1'b1; settle();
        chk("a_tdo_hs", {31'b0, tdo_m}, 32'd1);
        chk("a_no_done", {31'b0, done_m}, 32'd0);
        tick(); tdone = 1'b0; do_m = 1'b0; settle();
        chk("a_idle", {31'b0, tdo_m}, 32'd0);
        addr = 32'h2000; len = 3'd1; data = 32'h55; do_m = 1'b1; settle();
        chk("a_next_len", {29'b0, tl_m}, 32'd1);
        tick(); tdone = 1'b1; settle();
        chk("a_next_done", {31'b0, done_m}, 32'd1);
        tick(); tdone = 1'b0; do_m = 1'b0;

        // fault and done together in SECOND, then reset
        addr = 32'h100E; len = 3'd4; data = 32'h44332211; do_m = 1'b1;
        tick(); tdone = 1'b1;
        tick(); tac = 1'b1; settle();
        chk("x_second", {31'b0, sec_m}, 32'd1);
        chk("x_no_done", {31'b0, done_m}, 32'd0);
        tick(); tdone = 1'b0; tac = 1'b0; do_m = 1'b0; settle();
        chk("x_sticky_ac", {31'b0, ac_m}, 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; settle();
        chk("x_rst_ac", {31'b0, ac_m}, 32'd0);
        chk("x_rst_tdo", {31'b0, tdo_m}, 32'd0);
        do_m = 1'b1; settle();
        chk("x_idle_len1", {29'b0, tl_m}, 32'd2);
        chk("x_idle_sec", {31'b0, sec_m}, 32'd0);
        tick(); tdone = 1'b1;
        tick(); settle();
        chk("x_again_done", {31'b0, done_m}, 32'd1);
        tick(); tdone = 1'b0; do_m = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
